// File: rtl/mcs4_pkg.sv
// Shared definitions for the MCS-4 bus sequencer: subcycle encoding and timing helpers.
package mcs4_pkg;

  typedef enum logic [3:0] {
    SC_IDLE = 4'd0,
    SC_A1   = 4'd1,
    SC_A2   = 4'd2,
    SC_A3   = 4'd3,
    SC_A4   = 4'd4,
    SC_M1   = 4'd5,
    SC_M2   = 4'd6,
    SC_X1   = 4'd7,
    SC_X2   = 4'd8,
    SC_X3   = 4'd9
  } sub_e;

  localparam int SUB_LEN_DEFAULT = 8;

  // One-hot subcycle vector width: address subcycles plus M1, M2, X1, X2, X3.
  function automatic int sub_w(input int addr_nibbles);
    return addr_nibbles + 5;
  endfunction

  function automatic int sub_half(input int sub_len);
    return sub_len / 2;
  endfunction

endpackage

// File: rtl/mcs4_phase_gen.sv
// Subcycle counter with registered clk1/clk2 strobes, wrap indication and memory-wait hold.
module mcs4_phase_gen
  import mcs4_pkg::*;
#(
  parameter int SUB_LEN = SUB_LEN_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic act_d_i,
  input  logic wait_pt_i,
  input  logic wait_ok_i,
  output logic wrap_o,
  output logic clk1_o,
  output logic clk2_o
);

  localparam int CW = $clog2(SUB_LEN);
  localparam logic [CW-1:0] LAST = CW'(SUB_LEN - 1);
  localparam logic [CW-1:0] HALF = CW'(sub_half(SUB_LEN));

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clk1_q;
  logic          clk2_q;
  logic          hold;

  // The counter parks on its last count while the memory is not ready.
  assign hold   = run_i && wait_pt_i && !wait_ok_i && (cnt_q == LAST);
  assign wrap_o = run_i && !hold && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      clk1_q <= 1'b0;
      clk2_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk1_q <= act_d_i && (cnt_d == '0);
      clk2_q <= act_d_i && (cnt_d == HALF);
    end
  end

  assign clk1_o = clk1_q;
  assign clk2_o = clk2_q;

endmodule

// File: rtl/mcs4_bus_sequencer.sv
// MCS-4 bus-cycle sequencer: subcycle FSM, address drive, OPR/OPA capture, CM strobes.
// Optional memory wait handshake (wait_n port) enabled by defining MCS4_BUS_WAIT_EN.
module mcs4_bus_sequencer
  import mcs4_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int ADDR_NIBBLES = 3,
  parameter int NUM_CMRAM    = 4,
  parameter int SUB_LEN      = SUB_LEN_DEFAULT
) (
  input  logic                           sysclk,
  input  logic                           poc,
  input  logic                           run,
  input  logic [ADDR_NIBBLES*DATA_W-1:0] pc,
  input  logic [NUM_CMRAM-1:0]           cmram_sel,
  input  logic                           io_m2,
  input  logic                           src_x3,
  input  logic                           wr_en,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           rd_en,
  input  logic [DATA_W-1:0]              data_in,
`ifdef MCS4_BUS_WAIT_EN
  input  logic                           wait_n,
`endif
  output logic [DATA_W-1:0]              data_out,
  output logic                           data_dir,
  output logic                           clk1,
  output logic                           clk2,
  output logic [ADDR_NIBBLES+4:0]        subcycle,
  output logic                           sync,
  output logic [DATA_W-1:0]              opr,
  output logic [DATA_W-1:0]              opa,
  output logic                           instr_valid,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           cmrom,
  output logic [NUM_CMRAM-1:0]           cmram
);

  localparam int   SUB_W  = sub_w(ADDR_NIBBLES);
  localparam int   PC_W   = ADDR_NIBBLES * DATA_W;
  localparam sub_e A_LAST = sub_e'(4'(int'(SC_A1) + ADDR_NIBBLES - 1));

  function automatic logic [SUB_W-1:0] sub_onehot(input sub_e s);
    logic [SUB_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (s == SC_IDLE) return '0;
    if (s <= SC_A4) return one << (int'(s) - int'(SC_A1));
    return one << (ADDR_NIBBLES + int'(s) - int'(SC_M1));
  endfunction

  sub_e                 state_q, state_d;
  logic                 go, wrap, wait_ok, wait_pt, cm_on;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [NUM_CMRAM-1:0] cmsel_q, cmsel_d, cmram_q, cmram_d;
  logic                 rd_arm_q, rd_arm_d;
  logic                 data_dir_q, data_dir_d, cmrom_q, cmrom_d, sync_q, sync_d;
  logic                 instr_valid_q, instr_valid_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d, opr_q, opr_d, opa_q, opa_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [SUB_W-1:0]     sub_q, sub_d;

`ifdef MCS4_BUS_WAIT_EN
  assign wait_ok = wait_n;
`else
  assign wait_ok = 1'b1;
`endif
  assign wait_pt = state_q inside {SC_M1, SC_M2, SC_X2};

  mcs4_phase_gen #(.SUB_LEN(SUB_LEN)) u_phase (
    .clk_i     (sysclk),
    .rst_i     (poc),
    .run_i     (state_q != SC_IDLE),
    .act_d_i   (state_d != SC_IDLE),
    .wait_pt_i (wait_pt),
    .wait_ok_i (wait_ok),
    .wrap_o    (wrap),
    .clk1_o    (clk1),
    .clk2_o    (clk2)
  );

  always_comb begin
    go      = (state_q == SC_IDLE) && run;
    state_d = state_q;
    if (go) begin
      state_d = SC_A1;
    end else if (wrap) begin
      if (state_q == A_LAST)     state_d = SC_M1;
      else if (state_q == SC_X3) state_d = run ? SC_A1 : SC_IDLE;
      else                       state_d = sub_e'(state_q + 4'd1);
    end
  end

  // Every pad-facing value is decided at subcycle entry and registered, so the
  // pads see the new subcycle's drive from its count 0 onward.
  always_comb begin
    pc_d          = pc_q;
    cmsel_d       = cmsel_q;
    rd_arm_d      = rd_arm_q;
    data_dir_d    = data_dir_q;
    data_out_d    = data_out_q;
    cmrom_d       = cmrom_q;
    cmram_d       = cmram_q;
    opr_d         = opr_q;
    opa_d         = opa_q;
    rd_data_d     = rd_data_q;
    instr_valid_d = 1'b0;
    rd_valid_d    = 1'b0;
    cm_on         = 1'b0;
    sub_d         = sub_onehot(state_d);
    sync_d        = (state_d == SC_X3);
    if (go || wrap) begin
      data_dir_d = 1'b0;
      rd_arm_d   = 1'b0;
      if (state_d == SC_A1) begin
        pc_d    = pc;
        cmsel_d = cmram_sel;
      end
      if (state_d inside {SC_A1, SC_A2, SC_A3, SC_A4}) begin
        data_dir_d = 1'b1;
        data_out_d = DATA_W'(pc_d >> (DATA_W * (int'(state_d) - int'(SC_A1))));
      end
      if (state_d == SC_X2) begin
        if (wr_en) begin
          data_dir_d = 1'b1;
          data_out_d = wr_data;
        end
        rd_arm_d = rd_en && !wr_en;
      end
      cm_on   = (state_d == A_LAST) || (state_d == SC_M2 && io_m2) ||
                (state_d == SC_X3 && src_x3);
      cmrom_d = cm_on;
      cmram_d = cm_on ? cmsel_d : '0;
    end
    if (wrap && state_q == SC_M1) opr_d = data_in;
    if (wrap && state_q == SC_M2) begin
      opa_d         = data_in;
      instr_valid_d = 1'b1;
    end
    if (wrap && state_q == SC_X2 && rd_arm_q) begin
      rd_data_d  = data_in;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state_q       <= SC_IDLE;
      pc_q          <= '0;
      cmsel_q       <= '0;
      rd_arm_q      <= 1'b0;
      data_dir_q    <= 1'b0;
      data_out_q    <= '0;
      cmrom_q       <= 1'b0;
      cmram_q       <= '0;
      opr_q         <= '0;
      opa_q         <= '0;
      rd_data_q     <= '0;
      instr_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      sub_q         <= '0;
      sync_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cmsel_q       <= cmsel_d;
      rd_arm_q      <= rd_arm_d;
      data_dir_q    <= data_dir_d;
      data_out_q    <= data_out_d;
      cmrom_q       <= cmrom_d;
      cmram_q       <= cmram_d;
      opr_q         <= opr_d;
      opa_q         <= opa_d;
      rd_data_q     <= rd_data_d;
      instr_valid_q <= instr_valid_d;
      rd_valid_q    <= rd_valid_d;
      sub_q         <= sub_d;
      sync_q        <= sync_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_dir    = data_dir_q;
  assign subcycle    = sub_q;
  assign sync        = sync_q;
  assign opr         = opr_q;
  assign opa         = opa_q;
  assign instr_valid = instr_valid_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign cmrom       = cmrom_q;
  assign cmram       = cmram_q;

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Self-checking bench for mcs4_bus_sequencer (default parameters); the wait
// handshake scenario is included when MCS4_BUS_WAIT_EN is defined.
module tb_mcs4_bus_sequencer;

  logic        sysclk = 1'b0;
  logic        poc = 1'b1;
  logic        run = 1'b0;
  logic [11:0] pc = '0;
  logic [3:0]  cmram_sel = '0;
  logic        io_m2 = 1'b0;
  logic        src_x3 = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  data_in = '0;
`ifdef MCS4_BUS_WAIT_EN
  logic        wait_n = 1'b1;
`endif
  logic [3:0]  data_out;
  logic        data_dir, clk1, clk2, sync, instr_valid, rd_valid, cmrom;
  logic [7:0]  subcycle;
  logic [3:0]  opr, opa, rd_data, cmram;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_checks = 0;
  int          g_off = -1;
  logic [3:0]  p_m1, p_m2, p_x2;
  logic [3:0]  exp_opr = '0, exp_opa = '0, exp_rd = '0, exp_dout = '0;

  always #5 sysclk = ~sysclk;

  mcs4_bus_sequencer dut (
    .sysclk      (sysclk),
    .poc         (poc),
    .run         (run),
    .pc          (pc),
    .cmram_sel   (cmram_sel),
    .io_m2       (io_m2),
    .src_x3      (src_x3),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .data_in     (data_in),
`ifdef MCS4_BUS_WAIT_EN
    .wait_n      (wait_n),
`endif
    .data_out    (data_out),
    .data_dir    (data_dir),
    .clk1        (clk1),
    .clk2        (clk2),
    .subcycle    (subcycle),
    .sync        (sync),
    .opr         (opr),
    .opa         (opa),
    .instr_valid (instr_valid),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .cmrom       (cmrom),
    .cmram       (cmram)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (offset %0d): got %0h expected %0h", tag, g_off, got, exp);
    end
  endtask

  task automatic set_params(input logic [11:0] a, input logic [3:0] sel, input logic io,
                            input logic src, input logic wr, input logic [3:0] wd,
                            input logic rd, input logic [3:0] m1, input logic [3:0] m2,
                            input logic [3:0] x2);
    pc = a; cmram_sel = sel; io_m2 = io; src_x3 = src;
    wr_en = wr; wr_data = wd; rd_en = rd; p_m1 = m1; p_m2 = m2; p_x2 = x2;
  endtask

  task automatic random_params(input bit force_wr);
    set_params(12'($urandom), 4'(1 << $urandom_range(3, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), force_wr ? 1'b1 : 1'($urandom_range(1, 0)),
               4'($urandom), 1'($urandom_range(1, 0)), 4'($urandom), 4'($urandom),
               4'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'(0));
    check({tag, "_data_dir"}, 32'(data_dir), 32'(0));
    check({tag, "_clk1"}, 32'(clk1), 32'(0));
    check({tag, "_clk2"}, 32'(clk2), 32'(0));
    check({tag, "_subcycle"}, 32'(subcycle), 32'(0));
    check({tag, "_sync"}, 32'(sync), 32'(0));
    check({tag, "_opr"}, 32'(opr), 32'(0));
    check({tag, "_opa"}, 32'(opa), 32'(0));
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'(0));
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_rd_data"}, 32'(rd_data), 32'(0));
    check({tag, "_cmrom"}, 32'(cmrom), 32'(0));
    check({tag, "_cmram"}, 32'(cmram), 32'(0));
  endtask

  // Reference: one instruction cycle is 8 subcycles of 8 sysclk; offset 0 is A1 count 0.
  task automatic run_cycle(input int abort_at);
    int   sub, cnt, n_sync, n_iv, n_dir;
    logic cm, dir;
    n_sync = 0; n_iv = 0; n_dir = 0;
    for (int off = 0; off < 64; off++) begin
      @(negedge sysclk);
      g_off = off;
      sub = off / 8;
      cnt = off % 8;
      if (cnt == 0 && sub < 3) exp_dout = 4'(pc >> (4 * sub));
      if (off == 48 && wr_en) exp_dout = wr_data;
      if (off == 32) exp_opr = p_m1;
      if (off == 40) exp_opa = p_m2;
      if (off == 56 && rd_en && !wr_en) exp_rd = p_x2;
      dir = (sub < 3) || (sub == 6 && wr_en);
      cm  = (sub == 2) || (sub == 4 && io_m2) || (sub == 7 && src_x3);
      check("subcycle", 32'(subcycle), 32'(1) << sub);
      check("clk1", 32'(clk1), 32'(cnt == 0));
      check("clk2", 32'(clk2), 32'(cnt == 4));
      check("sync", 32'(sync), 32'(sub == 7));
      check("data_dir", 32'(data_dir), 32'(dir));
      check("data_out", 32'(data_out), 32'(exp_dout));
      check("cmrom", 32'(cmrom), 32'(cm));
      check("cmram", 32'(cmram), 32'(cm ? cmram_sel : 4'b0));
      check("opr", 32'(opr), 32'(exp_opr));
      check("opa", 32'(opa), 32'(exp_opa));
      check("instr_valid", 32'(instr_valid), 32'(off == 40));
      check("rd_valid", 32'(rd_valid), 32'(off == 56 && rd_en && !wr_en));
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      n_sync += int'(sync);
      n_iv   += int'(instr_valid);
      n_dir  += int'(data_dir);
      data_in = (sub == 3) ? p_m1 : (sub == 4) ? p_m2 : (sub == 6) ? p_x2 : 4'($urandom);
      if (off == abort_at) begin
        poc = 1'b1;
        #1;
        check_all_zero("poc_abort");
        @(negedge sysclk);
        @(negedge sysclk);
        exp_opr = '0; exp_opa = '0; exp_rd = '0; exp_dout = '0;
        poc = 1'b0;
        return;
      end
    end
    g_off = -1;
    check("sync_len", 32'(n_sync), 32'(8));
    check("instr_valid_count", 32'(n_iv), 32'(1));
    check("data_dir_len", 32'(n_dir), wr_en ? 32'(32) : 32'(24));
  endtask

`ifdef MCS4_BUS_WAIT_EN
  task automatic run_wait_cycle();
    int len;
    bit done;
    data_in = 4'hE;
    for (int off = 0; off < 32; off++) @(negedge sysclk);
    g_off = 31;
    check("wait_pre_sub", 32'(subcycle), 32'(8'b0000_1000));
    wait_n = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      check("wait_hold_sub", 32'(subcycle), 32'(8'b0000_1000));
      check("wait_hold_clk1", 32'(clk1), 32'(0));
      check("wait_hold_clk2", 32'(clk2), 32'(0));
      check("wait_hold_dir", 32'(data_dir), 32'(0));
      check("wait_hold_dout", 32'(data_out), 32'(exp_dout));
      check("wait_hold_opr", 32'(opr), 32'(exp_opr));
      if (i == 4) begin
        wait_n = 1'b1;
        data_in = 4'h2;
      end
    end
    @(negedge sysclk);
    check("wait_m2_sub", 32'(subcycle), 32'(8'b0001_0000));
    check("wait_m2_clk1", 32'(clk1), 32'(1));
    check("wait_opr", 32'(opr), 32'(4'h2));
    data_in = 4'h7;
    len = 38;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge sysclk);
      if (subcycle == '0) done = 1'b1;
      else len++;
    end
    check("wait_cycle_len", 32'(len), 32'(69));
    check("wait_opa", 32'(opa), 32'(4'h7));
    exp_opr = 4'h2;
    exp_opa = 4'h7;
  endtask
`endif

  initial begin
    repeat (3) @(negedge sysclk);
    check_all_zero("reset");
    poc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("idle_subcycle", 32'(subcycle), 32'(0));
      check("idle_clk1", 32'(clk1), 32'(0));
    end

    set_params(12'hA53, 4'b0100, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h2, 4'h7, 4'h9);
    run = 1'b1;
    run_cycle(-1);
    set_params(12'hA53, 4'b0100, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 4'h3, 4'h8, 4'h5);
    run_cycle(-1);
    set_params(12'h1F6, 4'b0001, 1'b0, 1'b1, 1'b1, 4'h4, 1'b1, 4'hB, 4'h1, 4'h6);
    run_cycle(-1);
    for (int c = 0; c < 6; c++) begin
      random_params(1'b0);
      run_cycle(-1);
    end
    random_params(1'b1);
    run_cycle(50);
    random_params(1'b0);
    run_cycle(-1);

`ifdef MCS4_BUS_WAIT_EN
    set_params(12'h3C1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h2, 4'h7, 4'h0);
    exp_dout = 4'h3;
    run_wait_cycle();
`else
    run = 1'b0;
`endif

    for (int i = 0; i < 16; i++) begin
      @(negedge sysclk);
      g_off = -1;
      check("end_idle_subcycle", 32'(subcycle), 32'(0));
      check("end_idle_clk1", 32'(clk1), 32'(0));
      check("end_idle_dir", 32'(data_dir), 32'(0));
      check("end_idle_sync", 32'(sync), 32'(0));
      check("end_idle_cmrom", 32'(cmrom), 32'(0));
      check("end_idle_dout", 32'(data_out), 32'(exp_dout));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
